// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with operand forwarding muxes,
//                flush / hold / bubble control and an optional bubble
//                counter enabled by the macro BUBBLE_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        pa_selector,
  input  logic [1:0]        pb_selector,
  input  logic              nop_signal,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pa,
  input  logic [DATA_W-1:0] id_pb,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_rf_enable,
  input  logic              id_load,
  input  logic              id_store,
  input  logic [3:0]        id_alu_op,
`ifdef BUBBLE_COUNT_EN
  output logic [15:0]       bubble_count,
`endif
  output logic              ex_valid,
  output logic              ex_rf_enable,
  output logic              ex_load_instruction,
  output logic              ex_store,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_W-1:0]  ex_rd,
  output logic [3:0]        ex_alu_op
);

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic              w_bubble;

  logic              valid_q, valid_d;
  logic              rf_en_q, rf_en_d;
  logic              load_q,  load_d;
  logic              store_q, store_d;
  logic [DATA_W-1:0] a_q,     a_d;
  logic [DATA_W-1:0] b_q,     b_d;
  logic [DATA_W-1:0] imm_q,   imm_d;
  logic [DATA_W-1:0] pc_q,    pc_d;
  logic [REG_W-1:0]  rd_q,    rd_d;
  logic [3:0]        alu_q,   alu_d;

  // Forwarding muxes: pick the freshest copy of each operand.
  always_comb begin
    unique case (pa_selector)
      2'b00:   w_op_a = id_pa;
      2'b01:   w_op_a = ex_result;
      2'b10:   w_op_a = mem_result;
      default: w_op_a = wb_result;
    endcase
    unique case (pb_selector)
      2'b00:   w_op_b = id_pb;
      2'b01:   w_op_b = ex_result;
      2'b10:   w_op_b = mem_result;
      default: w_op_b = wb_result;
    endcase
  end

  assign w_bubble = nop_signal | ~id_valid;

  // Next-state selection: flush beats hold, hold beats bubble, bubble beats load.
  always_comb begin
    valid_d = valid_q;
    rf_en_d = rf_en_q;
    load_d  = load_q;
    store_d = store_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    if (flush || (!ex_hold && w_bubble)) begin
      valid_d = 1'b0;
      rf_en_d = 1'b0;
      load_d  = 1'b0;
      store_d = 1'b0;
      a_d     = '0;
      b_d     = '0;
      imm_d   = '0;
      pc_d    = '0;
      rd_d    = '0;
      alu_d   = '0;
    end else if (!ex_hold) begin
      valid_d = 1'b1;
      // Never schedule a write-back to x0.
      rf_en_d = id_rf_enable & (id_rd != '0);
      load_d  = id_load;
      store_d = id_store;
      a_d     = w_op_a;
      b_d     = w_op_b;
      imm_d   = id_imm;
      pc_d    = id_pc;
      rd_d    = id_rd;
      alu_d   = id_alu_op;
    end
  end

  // Pipeline register; reset drops straight into the bubble state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rf_en_q <= 1'b0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rf_en_q <= rf_en_d;
      load_q  <= load_d;
      store_q <= store_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
    end
  end

  assign ex_valid            = valid_q;
  assign ex_rf_enable        = rf_en_q;
  assign ex_load_instruction = load_q;
  assign ex_store            = store_q;
  assign ex_a                = a_q;
  assign ex_b                = b_q;
  assign ex_imm              = imm_q;
  assign ex_pc               = pc_q;
  assign ex_rd               = rd_q;
  assign ex_alu_op           = alu_q;

`ifdef BUBBLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        w_cnt_evt;

  // Only hazard-driven bubbles count; empty ID slots are not stalls.
  assign w_cnt_evt = flush | (~ex_hold & nop_signal);

  // Saturating bubble counter.
  always_comb begin
    cnt_d = cnt_q;
    if (w_cnt_evt && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_count = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        pa_selector, pb_selector;
  logic              nop_signal, flush, ex_hold, id_valid;
  logic [DATA_W-1:0] id_pa, id_pb, id_imm, id_pc;
  logic [DATA_W-1:0] ex_result, mem_result, wb_result;
  logic [REG_W-1:0]  id_rd;
  logic              id_rf_enable, id_load, id_store;
  logic [3:0]        id_alu_op;
  logic              ex_valid, ex_rf_enable, ex_load_instruction, ex_store;
  logic [DATA_W-1:0] ex_a, ex_b, ex_imm, ex_pc;
  logic [REG_W-1:0]  ex_rd;
  logic [3:0]        ex_alu_op;
`ifdef BUBBLE_COUNT_EN
  logic [15:0]       bubble_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic              m_valid, m_rf, m_ld, m_st;
  logic [DATA_W-1:0] m_a, m_b, m_imm, m_pc;
  logic [REG_W-1:0]  m_rd;
  logic [3:0]        m_alu;
  int                m_cnt;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pa_selector(pa_selector), .pb_selector(pb_selector),
    .nop_signal(nop_signal), .flush(flush), .ex_hold(ex_hold), .id_valid(id_valid),
    .id_pa(id_pa), .id_pb(id_pb), .id_imm(id_imm), .id_pc(id_pc),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .id_rd(id_rd), .id_rf_enable(id_rf_enable), .id_load(id_load),
    .id_store(id_store), .id_alu_op(id_alu_op),
`ifdef BUBBLE_COUNT_EN
    .bubble_count(bubble_count),
`endif
    .ex_valid(ex_valid), .ex_rf_enable(ex_rf_enable),
    .ex_load_instruction(ex_load_instruction), .ex_store(ex_store),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_rf = 0; m_ld = 0; m_st = 0;
    m_a = '0; m_b = '0; m_imm = '0; m_pc = '0; m_rd = '0; m_alu = '0;
  endtask

  // What the stage should hold after the coming edge, from the current inputs.
  task automatic model_edge();
    logic [DATA_W-1:0] src_a [4];
    logic [DATA_W-1:0] src_b [4];
    src_a = '{id_pa, ex_result, mem_result, wb_result};
    src_b = '{id_pb, ex_result, mem_result, wb_result};
    if (flush || (!ex_hold && nop_signal)) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    if (flush) model_clear();
    else if (ex_hold) ;
    else if (nop_signal || !id_valid) model_clear();
    else begin
      m_valid = 1; m_rf = id_rf_enable && (id_rd != 0); m_ld = id_load; m_st = id_store;
      m_a = src_a[pa_selector]; m_b = src_b[pb_selector];
      m_imm = id_imm; m_pc = id_pc; m_rd = id_rd; m_alu = id_alu_op;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(ex_valid), 64'(m_valid));
    check({tag, ".rf_en"}, 64'(ex_rf_enable), 64'(m_rf));
    check({tag, ".load"},  64'(ex_load_instruction), 64'(m_ld));
    check({tag, ".store"}, 64'(ex_store), 64'(m_st));
    check({tag, ".a"},     64'(ex_a), 64'(m_a));
    check({tag, ".b"},     64'(ex_b), 64'(m_b));
    check({tag, ".imm"},   64'(ex_imm), 64'(m_imm));
    check({tag, ".pc"},    64'(ex_pc), 64'(m_pc));
    check({tag, ".rd"},    64'(ex_rd), 64'(m_rd));
    check({tag, ".alu"},   64'(ex_alu_op), 64'(m_alu));
`ifdef BUBBLE_COUNT_EN
    check({tag, ".bcnt"},  64'(bubble_count), 64'(m_cnt));
`endif
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_id();
    id_pa = $urandom; id_pb = $urandom; id_imm = $urandom; id_pc = $urandom;
    ex_result = $urandom; mem_result = $urandom; wb_result = $urandom;
    id_rd = ($urandom_range(0, 3) == 0) ? '0 : REG_W'($urandom);
    id_rf_enable = 1'($urandom); id_load = 1'($urandom); id_store = 1'($urandom);
    id_alu_op = 4'($urandom);
    pa_selector = 2'($urandom); pb_selector = 2'($urandom);
  endtask

  task automatic set_ctl(input logic f, input logic h, input logic n, input logic v);
    flush = f; ex_hold = h; nop_signal = n; id_valid = v;
  endtask

  initial begin
    m_cnt = 0;
    model_clear();
    rst_n = 1'b0;
    rand_id();
    set_ctl(0, 0, 0, 1);
    #3;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_edge");
    #6 rst_n = 1'b1;

    // Forward from EX into operand A
    rand_id(); set_ctl(0, 0, 0, 1);
    pa_selector = 2'b01; ex_result = 32'h0000_00AA;
    tick("fwd_ex_a");
    check("fwd_ex_a.lit", 64'(ex_a), 64'h0000_00AA);

    // Forward from WB into operand B, then plain register operand
    rand_id(); pb_selector = 2'b11; wb_result = 32'h1234_5678; id_pb = '0;
    tick("fwd_wb_b");
    check("fwd_wb_b.lit", 64'(ex_b), 64'h1234_5678);
    rand_id(); pb_selector = 2'b00;
    tick("rf_b");

    // Load-use bubble
    rand_id(); id_rd = 5'd7; id_rf_enable = 1; set_ctl(0, 0, 1, 1);
    tick("nop");
    check("nop.rd_lit", 64'(ex_rd), 64'h0);

    // Empty ID slot
    rand_id(); set_ctl(0, 0, 0, 0);
    tick("invalid");

    // Hold three cycles with changing inputs, then flush during hold
    rand_id(); set_ctl(0, 0, 0, 1);
    tick("pre_hold");
    for (int i = 0; i < 3; i++) begin
      rand_id(); set_ctl(0, 1, 1'($urandom), 1'($urandom));
      tick($sformatf("hold%0d", i));
    end
    rand_id(); set_ctl(1, 1, 0, 1);
    tick("flush_in_hold");

    // Write to x0 is suppressed; load+store both captured
    rand_id(); id_rd = '0; id_rf_enable = 1; id_load = 1; id_store = 1; set_ctl(0, 0, 0, 1);
    tick("x0");
    check("x0.rf_lit", 64'(ex_rf_enable), 64'h0);

    // Asynchronous reset between edges while holding a valid instruction
    rand_id(); set_ctl(0, 0, 0, 1);
    tick("pre_rst");
    ex_hold = 1; flush = 1;
    #2 rst_n = 1'b0;
    #1;
    model_clear(); m_cnt = 0;
    check_all("async_rst");
    #1 rst_n = 1'b1;
    set_ctl(0, 0, 0, 1);
    tick("post_rst");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      set_ctl($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0);
      tick("rand");
    end

`ifdef BUBBLE_COUNT_EN
    // Drive the counter to saturation, then confirm it sticks
    set_ctl(0, 0, 1, 1);
    for (int i = 0; i < 65535; i++) begin
      model_edge();
      @(posedge clk);
    end
    #1;
    check("bcnt_sat", 64'(bubble_count), 64'hFFFF);
    tick("bcnt_sat_nop");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
